// File: rtl/tick_receiver.sv
// Samples the slow divided clock clk_d as data in the clk domain: one-cycle tick per rising edge,
// wrapping tick count, rise-to-rise period measurement and stall timeout. Optional glitch filter: TICKRX_GLITCH_FILTER_EN.
module tick_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 27,
  parameter int TIMEOUT     = 120000000,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_d,
  output logic             tick,
  output logic [7:0]       tick_count,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             timeout
);

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl;
  logic                   prev_q;
  logic                   rise;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   tick_q, tick_d;
  logic [7:0]             count_q, count_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], clk_d};

`ifdef TICKRX_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);

  logic          lvl_q, lvl_d;
  logic [FW-1:0] run_q, run_d;

  // lvl follows the synchroniser only after FILTER_LEN consecutive differing cycles
  always_comb begin
    lvl_d = lvl_q;
    run_d = '0;
    if (sync_q[SYNC_STAGES-1] != lvl_q) begin
      if (run_q == FW'(FILTER_LEN - 1)) begin
        lvl_d = sync_q[SYNC_STAGES-1];
        run_d = '0;
      end else begin
        run_d = run_q + FW'(1);
      end
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q <= 1'b0;
      run_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      run_q <= run_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  assign rise = lvl & ~prev_q;

  // Counter, timeout and measurement state machine
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    period_d  = period_q;
    valid_d   = valid_q;
    tick_d    = rise;
    count_d   = count_q + {7'b0000000, rise};

    // A rise always wins over the timeout reaching its threshold in the same cycle
    if (rise) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (cnt_q < TIMEOUT_C) begin
      cnt_d     = cnt_q + CNT_W'(1);
      timeout_d = (cnt_d == TIMEOUT_C);
    end else begin
      cnt_d     = cnt_q;
      timeout_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
        end else begin
          state_d = IDLE;
        end
      end
      MEAS: begin
        if (rise && !timeout_q) begin
          period_d = cnt_q + CNT_W'(1);
          valid_d  = 1'b1;
        end else if (rise) begin
          state_d = MEAS;
        end else if (timeout_d && !timeout_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = MEAS;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      tick_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= lvl;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
    end
  end

  assign tick         = tick_q;
  assign tick_count   = count_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_receiver.sv
// Directed bench for tick_receiver: SYNC_STAGES=2, CNT_W=8, TIMEOUT=50, FILTER_LEN=4.
module tb_tick_receiver;

  localparam int CNT_W = 8;
`ifdef TICKRX_GLITCH_FILTER_EN
  localparam int LAT          = 7;
  localparam int GLITCH_TICKS = 0;
`else
  localparam int LAT          = 3;
  localparam int GLITCH_TICKS = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_d;
  logic             tick;
  logic [7:0]       tick_count;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int ticks_seen;

  tick_receiver #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W),
    .TIMEOUT    (50),
    .FILTER_LEN (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clk_d       (clk_d),
    .tick        (tick),
    .tick_count  (tick_count),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    clk_d = 1'b0;
    repeat (3) step();
    chk("rst_tick", tick, 0);
    chk("rst_count", tick_count, 0);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_timeout", timeout, 0);
    rst = 1'b0;

    // 20-cycle square wave, 10 rising edges
    for (int k = 0; k < 10; k++) begin
      clk_d = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        step();
        chk("wave_tick", tick, 32'(c == LAT));
        if (c == LAT) chk("wave_count", tick_count, k + 1);
        chk("wave_valid", period_valid, 32'(k * 20 + c >= 20 + LAT));
        chk("wave_period", period, (k * 20 + c >= 20 + LAT) ? 20 : 0);
        chk("wave_timeout", timeout, 0);
        if (c == 10) clk_d = 1'b0;
      end
    end
    chk("wave_final_count", tick_count, 10);

    // Held low: j counts edges since the last rise
    for (int j = 20 - LAT + 1; j <= 60; j++) begin
      step();
      chk("stall_timeout", timeout, 32'(j >= 50));
      chk("stall_valid", period_valid, 32'(j < 50));
      chk("stall_period", period, 20);
    end

    // Rise after timeout is a first edge; next rise 30 cycles later measures 30
    clk_d = 1'b1;
    for (int c = 1; c <= 30 + LAT; c++) begin
      step();
      if (c == LAT - 1) chk("recover_timeout_held", timeout, 1);
      if (c == LAT) begin
        chk("recover_tick", tick, 1);
        chk("recover_timeout_clr", timeout, 0);
        chk("recover_valid", period_valid, 0);
        chk("recover_period", period, 20);
      end
      if (c == 30 + LAT - 1) chk("p30_valid_before", period_valid, 0);
      if (c == 30 + LAT) begin
        chk("p30_tick", tick, 1);
        chk("p30_valid", period_valid, 1);
        chk("p30_period", period, 30);
      end
      if (c == 10) clk_d = 1'b0;
      if (c == 30) clk_d = 1'b1;
    end

    // Rise lands exactly when cnt would reach TIMEOUT
    for (int c = 1; c <= 50; c++) begin
      step();
      if (c == 49) begin
        chk("edge50_pre_timeout", timeout, 0);
        chk("edge50_pre_valid", period_valid, 1);
      end
      if (c == 50) begin
        chk("edge50_tick", tick, 1);
        chk("edge50_timeout", timeout, 0);
        chk("edge50_period", period, 50);
        chk("edge50_valid", period_valid, 1);
      end
      if (c == 10) clk_d = 1'b0;
      if (c == 50 - LAT) clk_d = 1'b1;
    end
    step();
    chk("edge50_post_timeout", timeout, 0);

    // One-cycle reset mid-wave with clk_d high
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_count", tick_count, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_valid", period_valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    rst = 1'b0;
    for (int c = 1; c <= 20 + LAT; c++) begin
      step();
      if (c == LAT) begin
        chk("post_rst_tick", tick, 1);
        chk("post_rst_count", tick_count, 1);
        chk("post_rst_valid", period_valid, 0);
        chk("post_rst_period", period, 0);
      end
      if (c == 20 + LAT - 1) chk("post_rst_valid_before", period_valid, 0);
      if (c == 20 + LAT) begin
        chk("post_rst_tick2", tick, 1);
        chk("post_rst_count2", tick_count, 2);
        chk("post_rst_valid2", period_valid, 1);
        chk("post_rst_period2", period, 20);
      end
      if (c == 10) clk_d = 1'b0;
      if (c == 20) clk_d = 1'b1;
    end

    // Two-cycle glitch, then a six-cycle pulse
    clk_d = 1'b0;
    repeat (20) step();
    clk_d = 1'b1;
    ticks_seen = 0;
    for (int c = 1; c <= 16; c++) begin
      step();
      ticks_seen += int'(tick);
      if (c == 2) clk_d = 1'b0;
    end
    chk("glitch_ticks", ticks_seen, GLITCH_TICKS);

    clk_d = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("pulse6_tick", tick, 32'(c == LAT));
      if (c == 6) clk_d = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
